uart_rx: RTL

UART receiver that consumes the 16x-oversample tick from the baud rate generator and deserialises the asynchronous rx line into parallel bytes. LSB-first framing: 1 start bit, DATA_BITS data bits, optional parity bit, stop bit(s). It pulses rx_done_tick once per frame with dout, frame_err and parity_err valid on that same cycle. It is the receive-side counterpart of the baud-tick/TX path in the TP2 UART.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity modes, default oversample ratio.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Must agree with the baud_rate_gen tick count per bit.
    localparam int DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the async rx line; 2 clk latency, resets to idle-high.
// No backpressure: samples every clk.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled, LSB-first, optional parity; done pulse one clk after the stop-bit sample.
// No backpressure: dout/frame_err/parity_err are overwritten by every completed frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int SB_TICKS   = 16,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int PARITY     = PARITY_NONE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 s_tick,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_done_tick,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int TICK_MAX = (OVERSAMPLE > SB_TICKS) ? OVERSAMPLE : SB_TICKS;
    localparam int SW       = $clog2(TICK_MAX);
    localparam int NW       = $clog2(DATA_BITS);

    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICKS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state, state_next;
    logic [SW-1:0]        s, s_next;
    logic [NW-1:0]        n, n_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 p, p_next;
    logic                 done_next;
    logic                 par_err_calc;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            s     <= '0;
            n     <= '0;
            shift <= '0;
            p     <= 1'b0;
        end else begin
            state <= state_next;
            s     <= s_next;
            n     <= n_next;
            shift <= shift_next;
            p     <= p_next;
        end
    end

    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        shift_next = shift;
        p_next     = p;
        case (state)
            // Start edge is taken immediately, not on a tick, so the half-bit count starts at the edge.
            ST_IDLE: begin
                if (!rx_s) begin
                    state_next = ST_START;
                    s_next     = '0;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s == S_MID) begin
                        if (!rx_s) begin
                            state_next = ST_DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s == S_BIT) begin
                        s_next     = '0;
                        shift_next = {rx_s, shift[DATA_BITS-1:1]};
                        if (n == N_LAST) begin
                            if (PARITY != PARITY_NONE) state_next = ST_PARITY;
                            else                       state_next = ST_STOP;
                        end else begin
                            n_next = n + 1'b1;
                        end
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (s == S_BIT) begin
                        p_next     = rx_s;
                        s_next     = '0;
                        state_next = ST_STOP;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (s == S_STOP) state_next = ST_IDLE;
                    else             s_next     = s + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        done_next = (state == ST_STOP) && s_tick && (s == S_STOP);
        if (PARITY == PARITY_ODD)       par_err_calc = ~(^{shift, p});
        else if (PARITY == PARITY_EVEN) par_err_calc = ^{shift, p};
        else                            par_err_calc = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            parity_err   <= 1'b0;
        end else begin
            rx_done_tick <= done_next;
            if (done_next) begin
                dout       <= shift;
                frame_err  <= ~rx_s;
                parity_err <= par_err_calc;
            end
        end
    end

endmodule
